// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts a word over valid/ready, shifts it LSB-first into an overlapping 1011 detector.
// Define SEQ_SCAN_WRAP_EN to rescan bits 0..2 after the last bit so patterns spanning the word boundary count.
module seq_scan_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              abort_i,
  output logic              bit_o,
  output logic              bit_vld_o,
  output logic              hit_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o
);

`ifdef SEQ_SCAN_WRAP_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int IDX_W = $clog2(NBITS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {D0, D1, D10, D101} det_t;

  state_t            state_reg;
  det_t              det_reg;
  det_t              det_next;
  logic              match;
  logic [DATA_W-1:0] shreg_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              ready_reg;
  logic              vld_reg;
  logic              hit_reg;
  logic              done_reg;

  // Overlapping detector: after a match the trailing 1 already counts as a fresh prefix.
  always_comb begin
    det_next = D0;
    match    = 1'b0;
    case (det_reg)
      D0:      det_next = shreg_reg[0] ? D1   : D0;
      D1:      det_next = shreg_reg[0] ? D1   : D10;
      D10:     det_next = shreg_reg[0] ? D101 : D0;
      D101: begin
        det_next = shreg_reg[0] ? D1 : D10;
        match    = shreg_reg[0];
      end
      default: det_next = D0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= S_IDLE;
      det_reg   <= D0;
      shreg_reg <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      ready_reg <= 1'b1;
      vld_reg   <= 1'b0;
      hit_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      hit_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start_i) begin
            shreg_reg <= data_i;
            idx_reg   <= '0;
            count_reg <= '0;
            det_reg   <= D0;
            ready_reg <= 1'b0;
            vld_reg   <= 1'b1;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Rotate rather than shift so the wrap option can revisit the low bits.
          shreg_reg <= {shreg_reg[0], shreg_reg[DATA_W-1:1]};
          idx_reg   <= idx_reg + IDX_W'(1);
          det_reg   <= det_next;
          if (abort_i) begin
            ready_reg <= 1'b1;
            vld_reg   <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            if (match) begin
              hit_reg <= 1'b1;
              if (count_reg != CNT_MAX) count_reg <= count_reg + CNT_W'(1);
            end
            if (idx_reg == IDX_LAST) begin
              vld_reg   <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: begin
          ready_reg <= 1'b1;
          vld_reg   <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o   = ready_reg;
  assign bit_o     = shreg_reg[0];
  assign bit_vld_o = vld_reg;
  assign hit_o     = hit_reg;
  assign done_o    = done_reg;
  assign count_o   = count_reg;

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that sequences the serial 1011 pattern-detection datapath. It accepts a parallel data word through a valid/ready handshake and serializes it LSB-first, one bit per clock. It runs an overlapping 1011 detector FSM on that stream and reports a saturating match count with a done pulse. It sits between a word-oriented producer and the bit-serial detection logic, replacing free-running rotate-register stimulus with a controlled, restartable scan.

## Interface
- DATA_W, 16: width of scanned word (≥4)
- CNT_W, 5: width of match counter
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  request to scan data_i
- data_i  in  DATA_W  word to scan, bit 0 first
- ready_o  out  1  high in IDLE; start_i accepted when start_i && ready_o
- abort_i  in  1  synchronous abort of an in-progress scan
- bit_o  out  1  serial bit currently presented to detector (shreg[0])
- bit_vld_o  out  1  high during every SHIFT cycle
- hit_o  out  1  one-cycle pulse, registered, per detected 1011
- done_o  out  1  one-cycle pulse at end of a complete scan
- count_o  out  CNT_W  number of matches in current/last scan

## Operation
- Top FSM: IDLE → SHIFT → DONE → IDLE.
- IDLE: ready_o=1, bit_vld_o=0. On accept: shreg←data_i, idx←0, count_o←0, detector←D0, go SHIFT.
- SHIFT: bit_vld_o=1, bit_o=shreg[0]. Each edge: detector consumes bit_o, shreg rotates right (shreg[0] moves to MSB), idx++. After consuming the last bit (idx = NBITS−1), go DONE. NBITS = DATA_W (DATA_W+3 with wrap, see Configuration).
- Detector FSM (overlapping), states D0 (none), D1 ("1"), D10, D101:
  - D0: 1→D1, 0→D0
  - D1: 1→D1, 0→D10
  - D10: 1→D101, 0→D0
  - D101: 1→D1 + match, 0→D10
- On match: hit_o=1 next cycle; count_o increments at the same edge, saturating at 2^CNT_W−1.
- DONE: done_o=1 for one cycle; count_o holds final value; next state IDLE.
- count_o holds until the next accept.
- abort_i in SHIFT: next edge → IDLE; no done_o; count_o keeps its partial value; hit_o for the bit consumed on that edge is suppressed. abort_i in IDLE/DONE is ignored (DONE still completes).
- start_i outside IDLE is ignored; no queuing.
- No state carries between scans; the detector restarts at D0 on every accept.

## Timing
- Reset values: ready_o=1, bit_o=0, bit_vld_o=0, hit_o=0, done_o=0, count_o=0; FSM IDLE, detector D0, shreg=0.
- Accept edge T. SHIFT occupies cycles T+1 … T+NBITS. done_o is high in cycle T+NBITS+1. ready_o is high again from T+NBITS+2.
- Bit k (k<DATA_W) is on bit_o in cycle T+1+k.
- hit_o for a pattern ending at bit k is high in cycle T+2+k, which is the DONE cycle when k is the last bit.
- Back-to-back minimum spacing between accepts: NBITS+2 cycles.
- rst_n_i low at any time immediately forces reset values. Mid-scan reset discards the scan.

## Configuration
- SEQ_SCAN_WRAP_EN defined: NBITS=DATA_W+3. After bit DATA_W−1, the rotated bits 0,1,2 are scanned again, so patterns spanning the word end→start wrap are counted.
- Not defined: NBITS=DATA_W. There is no wrap and no extra cycles.

## Test plan
- Reset: hold rst_n_i low mid-scan → all outputs at reset values at once; FSM IDLE after release, ready_o=1.
- Overlap: data_i=16'h006D, no wrap → hit_o in cycles T+5 and T+8, count_o=2, done_o at T+17.
- Wrap: data_i=16'h4003 → count_o=0 with done at T+17 without SEQ_SCAN_WRAP_EN; count_o=1 with done at T+20 with it.
- Saturation: CNT_W=2, data_i=16'hDB6D → 5 hit_o pulses, count_o=3 at done.
- Abort: start 16'h006D, abort_i high in cycle T+6 → IDLE next edge, no done_o, count_o=1, ready_o=1 at T+7.
- Handshake: start_i held high through a scan → only one accept per IDLE visit; second scan accepted at T+18 (no wrap).
